// File: rtl/oam_dma.sv
// OAM DMA controller and CPU/bus arbiter: a write to FF46 copies XFER_LEN bytes from page {FF46,00} into OAM.
// Optional build macro OAM_DMA_ECHO_EN: source pages E0-FF are folded onto the C0-DF WRAM echo.
module oam_dma #(
    parameter int CYCLES_PER_BYTE = 4,
    parameter int XFER_LEN        = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_data_w,
    input  logic        cpu_do_write,
    output logic [7:0]  cpu_data_r,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_data_w,
    output logic        bus_do_write,
    input  logic [7:0]  bus_data_r,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_data,
    output logic        oam_write,
    output logic        dma_active
);

    localparam int              CNT_W    = $clog2(CYCLES_PER_BYTE);
    localparam logic [CNT_W-1:0] CNT_CAP  = CNT_W'(CYCLES_PER_BYTE - 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_BYTE - 1);
    localparam logic [7:0]      IDX_LAST = 8'(XFER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_XFER
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       reg_q, reg_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       buf_q, buf_d;

    logic       ff46_hit;
    logic       hram_hit;
    logic       cpu_grant;
    logic       trigger;
    logic       byte_done;
    logic [7:0] src_hi;

    assign ff46_hit  = (cpu_addr == 16'hFF46);
    assign hram_hit  = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    assign cpu_grant = hram_hit || ff46_hit;
    assign trigger   = cpu_do_write && ff46_hit;

    // A granted CPU cycle freezes the byte engine, including the OAM write slot.
    assign byte_done = (state_q == S_XFER) && !cpu_grant && (cnt_q == CNT_LAST);

    always_comb begin
`ifdef OAM_DMA_ECHO_EN
        src_hi = (reg_q >= 8'hE0) ? (reg_q - 8'h20) : reg_q;
`else
        src_hi = reg_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        if (trigger) begin
            reg_d   = cpu_data_w;
            idx_d   = 8'h00;
            cnt_d   = '0;
            state_d = S_START;
        end else begin
            case (state_q)
                S_START: state_d = S_XFER;
                S_XFER: begin
                    if (!cpu_grant) begin
                        if (cnt_q == CNT_CAP) begin
                            buf_d = bus_data_r;
                        end
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            idx_d = idx_q + 8'h01;
                            if (idx_q == IDX_LAST) begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        dma_active   = (state_q != S_IDLE);
        oam_write    = byte_done;
        oam_addr     = idx_q;
        oam_data     = buf_q;
        bus_addr     = cpu_addr;
        bus_data_w   = cpu_data_w;
        bus_do_write = cpu_do_write;
        cpu_data_r   = bus_data_r;
        if (dma_active && !cpu_grant) begin
            bus_addr     = {src_hi, idx_q};
            bus_data_w   = 8'h00;
            bus_do_write = 1'b0;
            cpu_data_r   = 8'hFF;
        end
        // The DMA register has no other decoder, so its readback is sourced here.
        if (ff46_hit) begin
            cpu_data_r = reg_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            reg_q   <= 8'hFF;
            idx_q   <= 8'h00;
            cnt_q   <= '0;
            buf_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

endmodule
